// File: rtl/voice_scheduler_if.sv
// Request/response link between the voice scheduler and the shared
// wave-generator pipeline. The scheduler is the master (it issues voice
// requests and consumes results); the pipeline is the slave.
interface voice_scheduler_if #(
  parameter int N_VOICES = 8,
  parameter int SAMPLE_W = 24
);
  localparam int IDX_W = $clog2(N_VOICES);

  logic                       req_valid;
  logic [IDX_W-1:0]           req_voice;
  logic                       req_ready;
  logic                       resp_valid;
  logic [IDX_W-1:0]           resp_voice;
  logic signed [SAMPLE_W-1:0] resp_sample;

  modport master (
    output req_valid,
    output req_voice,
    input  req_ready,
    input  resp_valid,
    input  resp_voice,
    input  resp_sample
  );

  modport slave (
    input  req_valid,
    input  req_voice,
    output req_ready,
    output resp_valid,
    output resp_voice,
    output resp_sample
  );
endinterface

// File: rtl/voice_scheduler.sv
// Voice scheduler: once per sample tick, snapshots the active-voice mask,
// issues one wavegen request per active voice (lowest index first), sums the
// returned samples and presents one mixed sample per frame.
module voice_scheduler #(
  parameter int N_VOICES = 8,
  parameter int IDX_W    = $clog2(N_VOICES),
  parameter int SAMPLE_W = 24,
  parameter int ACC_W    = SAMPLE_W + IDX_W
) (
  input  logic                    sys_clk,
  input  logic                    rstn,
  input  logic                    sample_tick,
  input  logic                    enable,
  input  logic [N_VOICES-1:0]     voice_active,
  voice_scheduler_if.master       wg,
  output logic                    mix_valid,
  output logic signed [ACC_W-1:0] mix_sample,
  output logic                    busy,
  output logic                    overrun,
  output logic                    resp_err,
  input  logic                    err_clr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [N_VOICES-1:0]     r_todo;
  logic [N_VOICES-1:0]     r_pend;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_mix_sample;
  logic                    r_overrun;
  logic                    r_resp_err;

  logic [N_VOICES-1:0]     w_todo_next;
  logic [N_VOICES-1:0]     w_pend_next;
  logic [N_VOICES-1:0]     w_issue_mask;
  logic [N_VOICES-1:0]     w_resp_mask;
  logic [IDX_W-1:0]        w_req_voice;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_resp_ext;
  logic                    w_frame_start;
  logic                    w_xfer;
  logic                    w_resp_window;
  logic                    w_resp_hit;
  logic                    w_resp_err_set;
  logic                    w_overrun_set;

  // Lowest set bit of a voice mask; zero when the mask is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_VOICES-1:0] mask);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = N_VOICES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // One-hot decode of a voice index.
  function automatic logic [N_VOICES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_VOICES-1:0] vec;
    vec      = {N_VOICES{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Issue selection, response matching and next values of masks/accumulator.
  always_comb begin
    w_req_voice    = lowest_set(r_todo);
    w_frame_start  = (r_state == S_IDLE) && sample_tick && enable;
    w_xfer         = (r_state == S_ISSUE) && wg.req_ready;
    w_resp_window  = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    // A voice must already be pending; the voice issued this very cycle is not.
    w_resp_hit     = wg.resp_valid && w_resp_window && r_pend[wg.resp_voice];
    w_resp_err_set = wg.resp_valid && !w_resp_hit;
    w_overrun_set  = sample_tick && (r_state != S_IDLE);
    w_resp_ext     = {{IDX_W{wg.resp_sample[SAMPLE_W-1]}}, wg.resp_sample};

    if (w_xfer) begin
      w_issue_mask = onehot(w_req_voice);
    end else begin
      w_issue_mask = {N_VOICES{1'b0}};
    end

    if (w_resp_hit) begin
      w_resp_mask = onehot(wg.resp_voice);
      w_acc_next  = r_acc + w_resp_ext;
    end else begin
      w_resp_mask = {N_VOICES{1'b0}};
      w_acc_next  = r_acc;
    end

    w_todo_next = r_todo & ~w_issue_mask;
    w_pend_next = (r_pend & ~w_resp_mask) | w_issue_mask;
  end

  // Next-state logic of the frame sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_frame_start) begin
          if (voice_active != {N_VOICES{1'b0}}) begin
            w_next_state = S_ISSUE;
          end else begin
            w_next_state = S_DONE;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_todo_next == {N_VOICES{1'b0}}) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the last outstanding response lands this cycle.
        if (w_pend_next == {N_VOICES{1'b0}}) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Per-frame work masks and running sum; a new frame snapshots the mask.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_todo <= {N_VOICES{1'b0}};
      r_pend <= {N_VOICES{1'b0}};
      r_acc  <= {ACC_W{1'b0}};
    end else if (w_frame_start) begin
      r_todo <= voice_active;
      r_pend <= {N_VOICES{1'b0}};
      r_acc  <= {ACC_W{1'b0}};
    end else begin
      r_todo <= w_todo_next;
      r_pend <= w_pend_next;
      r_acc  <= w_acc_next;
    end
  end

  // Mixed output: loaded on entry to DONE so it is valid with mix_valid, held otherwise.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_mix_sample <= {ACC_W{1'b0}};
    end else if (w_next_state == S_DONE && r_state != S_DONE) begin
      if (w_frame_start) begin
        r_mix_sample <= {ACC_W{1'b0}};
      end else begin
        r_mix_sample <= w_acc_next;
      end
    end else begin
      r_mix_sample <= r_mix_sample;
    end
  end

  // Sticky error flags; a new event wins over a coincident clear.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_overrun  <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
      if (w_resp_err_set) begin
        r_resp_err <= 1'b1;
      end else if (err_clr) begin
        r_resp_err <= 1'b0;
      end else begin
        r_resp_err <= r_resp_err;
      end
    end
  end

  assign wg.req_valid = (r_state == S_ISSUE);
  assign wg.req_voice = w_req_voice;
  assign mix_valid    = (r_state == S_DONE);
  assign mix_sample   = r_mix_sample;
  assign busy         = (r_state != S_IDLE);
  assign overrun      = r_overrun;
  assign resp_err     = r_resp_err;

endmodule
